// File: rtl/gtech_bist_pkg.sv
// Shared types and constants for the 3-input cell BIST: FSM states, vector
// count and result widths.
package gtech_bist_pkg;

  localparam int NUM_VEC = 8;
  localparam int IDX_W   = 3;
  localparam int ERR_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FIN    = 2'd3
  } state_e;

  // Mismatch counter increment that sticks at NUM_VEC instead of wrapping.
  function automatic logic [ERR_W-1:0] err_inc(input logic [ERR_W-1:0] v);
    return (v >= ERR_W'(NUM_VEC)) ? v : v + ERR_W'(1);
  endfunction

endpackage

// File: rtl/gtech_cell_bist_if.sv
// Bundle between the BIST controller and its environment: run control,
// expected truth table, stimulus/response of the cell and the run results.
interface gtech_cell_bist_if;
  import gtech_bist_pkg::*;

  logic                 START;
  logic [NUM_VEC-1:0]   EXP_TT;
  logic                 Z_DUT;
  logic                 A;
  logic                 B;
  logic                 C;
  logic                 BUSY;
  logic                 DONE;
  logic                 PASS;
  logic [ERR_W-1:0]     ERR_CNT;
  logic [IDX_W-1:0]     FAIL_IDX;

  modport master (
    output START, EXP_TT, Z_DUT,
    input  A, B, C, BUSY, DONE, PASS, ERR_CNT, FAIL_IDX
  );

  modport slave (
    input  START, EXP_TT, Z_DUT,
    output A, B, C, BUSY, DONE, PASS, ERR_CNT, FAIL_IDX
  );

endinterface

// File: rtl/gtech_bist_vecgen.sv
// Vector index and settle counter for the cell BIST; flags the last settle
// cycle of a vector and the last vector of a run.
module gtech_bist_vecgen
  import gtech_bist_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic             CP,
  input  logic             CD,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic             tick_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [IDX_W-1:0] idx_nxt_o,
  output logic             last_settle_o,
  output logic             last_vec_o
);

  localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;

  always_comb begin
    idx_d = idx_q;
    if (load_i)     idx_d = '0;
    else if (adv_i) idx_d = idx_q + IDX_W'(1);
  end

  // The settle counter restarts whenever the FSM is not holding in DRIVE.
  assign cnt_d = (tick_i && !last_settle_o) ? cnt_q + 4'd1 : 4'd0;

  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end

  assign idx_o         = idx_q;
  assign idx_nxt_o     = idx_d;
  assign last_settle_o = (SETTLE == 0) || (cnt_q == SETTLE_LAST);
  assign last_vec_o    = (idx_q == IDX_W'(NUM_VEC - 1));

endmodule

// File: rtl/gtech_cell_bist.sv
// Exhaustive BIST for a 3-input cell: applies all 8 input vectors, compares
// the response against a latched truth table and reports count/first failure.
module gtech_cell_bist
  import gtech_bist_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic              CP,
  input  logic              CD,
  gtech_cell_bist_if.slave  bus
);

  // With no settle time a vector goes straight to its compare cycle.
  localparam state_e FIRST = (SETTLE == 0) ? SAMPLE : DRIVE;

  state_e               state_q, state_d;
  logic [NUM_VEC-1:0]   exp_q, exp_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic [IDX_W-1:0]     fidx_q, fidx_d;
  logic                 pass_q, pass_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2:0]           abc_q, abc_d;

  logic                 load, adv, tick, mismatch;
  logic                 last_settle, last_vec;
  logic [IDX_W-1:0]     idx, idx_nxt;

  gtech_bist_vecgen #(.SETTLE(SETTLE)) u_vecgen (
    .CP            (CP),
    .CD            (CD),
    .load_i        (load),
    .adv_i         (adv),
    .tick_i        (tick),
    .idx_o         (idx),
    .idx_nxt_o     (idx_nxt),
    .last_settle_o (last_settle),
    .last_vec_o    (last_vec)
  );

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    err_d    = err_q;
    fidx_d   = fidx_q;
    pass_d   = pass_q;
    load     = 1'b0;
    adv      = 1'b0;
    tick     = 1'b0;
    mismatch = 1'b0;

    unique case (state_q)
      IDLE, FIN: begin
        if (bus.START) begin
          load    = 1'b1;
          exp_d   = bus.EXP_TT;
          err_d   = '0;
          fidx_d  = '0;
          pass_d  = 1'b0;
          state_d = FIRST;
        end
      end
      DRIVE: begin
        tick = 1'b1;
        if (last_settle) state_d = SAMPLE;
      end
      SAMPLE: begin
        mismatch = (bus.Z_DUT != exp_q[idx]);
        if (mismatch) begin
          err_d = err_inc(err_q);
          if (err_q == '0) fidx_d = idx;
        end
        if (last_vec) begin
          state_d = FIN;
          pass_d  = (err_d == '0);
        end else begin
          adv     = 1'b1;
          state_d = FIRST;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they align with it.
    busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
    done_d = (state_d == FIN);
    abc_d  = busy_d ? idx_nxt : 3'b000;
  end

  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      state_q <= IDLE;
      exp_q   <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abc_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abc_q   <= abc_d;
    end
  end

  assign bus.A        = abc_q[2];
  assign bus.B        = abc_q[1];
  assign bus.C        = abc_q[0];
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.PASS     = pass_q;
  assign bus.ERR_CNT  = err_q;
  assign bus.FAIL_IDX = fidx_q;

endmodule
